// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: frame geometry, FSM states and parity helper.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_LAST_CAPT  = PS2_FRAME_BITS - 2;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } ps2_state_e;

  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
  } ps2_frame_t;

  function automatic logic odd_parity_ok(input logic [7:0] b, input logic parity_bit);
    return ^{b, parity_bit};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO succeeds only when paired with a pop.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] w_ptr_q, w_ptr_d;
  logic [DEPTH_LOG2-1:0] r_ptr_q, r_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  do_push_c, do_pop_c;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LVL_W'(DEPTH));
  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);
  assign rdata     = mem[r_ptr_q];
  assign level     = level_q;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    level_d = level_q;
    if (do_push_c) w_ptr_d = w_ptr_q + DEPTH_LOG2'(1);
    if (do_pop_c)  r_ptr_d = r_ptr_q + DEPTH_LOG2'(1);
    if (do_push_c && !do_pop_c)      level_d = level_q + LVL_W'(1);
    else if (!do_push_c && do_pop_c) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      level_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      level_q <= level_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[w_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, clock deglitch filter, frame FSM
// with watchdog, sticky error flags and a byte FIFO toward the reader.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 3,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  pop,
  input  logic                  clr_err,
  output logic [7:0]            data,
  output logic                  valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]        clk_s_q, dat_s_q;
  logic              filt_q, filt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              strobe_c, dat_c;

  ps2_state_e        state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [8:0]        shift_q, shift_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  ps2_frame_t        frame_c;
  logic              push_c, par_set_c, frm_set_c, ovf_set_c;
  logic              ovf_q, par_q, frm_q;
  logic              fifo_full, fifo_empty;

  assign dat_c = dat_s_q[1];

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s_q[1] != filt_q) begin
      if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) filt_d = ~filt_q;
      else                                   fcnt_d = fcnt_q + FCNT_W'(1);
    end
  end

  assign strobe_c = filt_q && !filt_d;
  assign frame_c  = '{stop: dat_c, parity: shift_q[8], data: shift_q[7:0]};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wd_d      = wd_q;
    push_c    = 1'b0;
    par_set_c = 1'b0;
    frm_set_c = 1'b0;
    case (state_q)
      IDLE: begin
        wd_d      = '0;
        bit_cnt_d = '0;
        if (strobe_c && !dat_c) state_d = RECV;
      end
      RECV: begin
        if (strobe_c) begin
          wd_d      = '0;
          shift_d   = {dat_c, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(PS2_LAST_CAPT)) begin
            state_d   = IDLE;
            par_set_c = !odd_parity_ok(frame_c.data, frame_c.parity);
            frm_set_c = !frame_c.stop;
            push_c    = !par_set_c && !frm_set_c;
          end
        end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          state_d   = IDLE;
          frm_set_c = 1'b1;
          wd_d      = '0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ovf_set_c = push_c && fifo_full && !(pop && valid);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_s_q   <= 2'b11;
      dat_s_q   <= 2'b11;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      wd_q      <= '0;
      ovf_q     <= 1'b0;
      par_q     <= 1'b0;
      frm_q     <= 1'b0;
    end else begin
      clk_s_q   <= {clk_s_q[0], ps2_clk};
      dat_s_q   <= {dat_s_q[0], ps2_data};
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      wd_q      <= wd_d;
      // Set beats a simultaneous clear.
      ovf_q     <= ovf_set_c || (ovf_q && !clr_err);
      par_q     <= par_set_c || (par_q && !clr_err);
      frm_q     <= frm_set_c || (frm_q && !clr_err);
    end
  end

  sync_fifo #(
    .WIDTH     (8),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk  (clk),
    .clrn (clrn),
    .push (push_c),
    .pop  (pop),
    .wdata(frame_c.data),
    .rdata(data),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(level)
  );

  assign valid      = !fifo_empty;
  assign overflow   = ovf_q;
  assign parity_err = par_q;
  assign frame_err  = frm_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: vector table, directed corner sequences and random
// frames checked against a queue-based reference model.
module tb_ps2_rx_fifo;

  localparam int unsigned DL2 = 3;
  localparam int unsigned FL  = 4;
  localparam int unsigned TO  = 300;
  localparam int unsigned H   = 10;
  localparam int unsigned CAP = 2 ** DL2;

  logic         clk = 1'b0;
  logic         clrn, ps2_clk, ps2_data, pop, clr_err;
  logic [7:0]   data;
  logic         valid;
  logic [DL2:0] level;
  logic         overflow, parity_err, frame_err;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.DEPTH_LOG2(DL2), .FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .pop(pop), .clr_err(clr_err), .data(data), .valid(valid), .level(level),
    .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mq[$];
  bit m_ovf, m_par, m_frm;

  typedef struct {
    logic [7:0] d;
    bit         flip;
    bit         stop;
    int         lvl;
    logic [7:0] head;
    bit         par;
    bit         frm;
  } vec_t;
  vec_t vt[4];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string nm);
    chk({nm, ".level"}, 32'(level), 32'(mq.size()));
    chk({nm, ".valid"}, 32'(valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk({nm, ".data"}, 32'(data), 32'(mq[0]));
    chk({nm, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({nm, ".parity_err"}, 32'(parity_err), 32'(m_par));
    chk({nm, ".frame_err"}, 32'(frame_err), 32'(m_frm));
  endtask

  // Reference: odd parity by population count, FIFO as a bounded queue.
  task automatic model_frame(input logic [7:0] d, input logic p, input logic stop);
    bit par_ok;
    par_ok = ($countones({d, p}) % 2) == 1;
    if (!par_ok) m_par = 1'b1;
    if (!stop)   m_frm = 1'b1;
    if (par_ok && stop) begin
      if (mq.size() < CAP) mq.push_back(d);
      else                 m_ovf = 1'b1;
    end
  endtask

  task automatic phase(input logic lvl, input bit glitch);
    ps2_clk = lvl;
    if (glitch) begin
      tick(4);
      ps2_clk = ~lvl;
      tick(2);
      ps2_clk = lvl;
      tick(H - 6);
    end else begin
      tick(H);
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      phase(1'b1, glitch);
      phase(1'b0, glitch);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(H);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop,
                            input bit glitch, input bit pop_at_stop);
    logic       p;
    logic [10:0] f;
    p = ~(^d) ^ flip;
    f = {stop, p, d, 1'b0};
    if (!pop_at_stop) begin
      send_bits(f, 11, glitch);
    end else begin
      send_bits(f, 10, 1'b0);
      ps2_data = f[10];
      tick(H);
      // The stop-bit strobe lands on the 6th edge after the falling line.
      ps2_clk = 1'b0;
      tick(5);
      pop = 1'b1;
      tick(1);
      pop = 1'b0;
      tick(H - 6);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      tick(H);
      if (mq.size() != 0) void'(mq.pop_front());
    end
    model_frame(d, p, stop);
  endtask

  task automatic pop_n(input int k);
    for (int i = 0; i < k; i++) begin
      pop = 1'b1;
      tick(1);
      pop = 1'b0;
      if (mq.size() != 0) void'(mq.pop_front());
    end
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    tick(2);
    clrn = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    m_par = 1'b0;
    m_frm = 1'b0;
  endtask

  initial begin
    vt[0] = '{d: 8'h1C, flip: 1'b0, stop: 1'b1, lvl: 1, head: 8'h1C, par: 1'b0, frm: 1'b0};
    vt[1] = '{d: 8'hA5, flip: 1'b1, stop: 1'b1, lvl: 1, head: 8'h1C, par: 1'b1, frm: 1'b0};
    vt[2] = '{d: 8'h3C, flip: 1'b0, stop: 1'b0, lvl: 1, head: 8'h1C, par: 1'b1, frm: 1'b1};
    vt[3] = '{d: 8'h00, flip: 1'b0, stop: 1'b1, lvl: 2, head: 8'h1C, par: 1'b1, frm: 1'b1};

    ps2_clk = 1'b1; ps2_data = 1'b1; pop = 1'b0; clr_err = 1'b0; clrn = 1'b0;
    tick(1);
    do_reset();
    chk("reset.level", 32'(level), 0);
    chk("reset.valid", 32'(valid), 0);
    chk("reset.flags", 32'({overflow, parity_err, frame_err}), 0);

    for (int i = 0; i < 4; i++) begin
      send_frame(vt[i].d, vt[i].flip, vt[i].stop, 1'b0, 1'b0);
      chk($sformatf("vec%0d.level", i), 32'(level), 32'(vt[i].lvl));
      chk($sformatf("vec%0d.data", i), 32'(data), 32'(vt[i].head));
      chk($sformatf("vec%0d.parity_err", i), 32'(parity_err), 32'(vt[i].par));
      chk($sformatf("vec%0d.frame_err", i), 32'(frame_err), 32'(vt[i].frm));
    end

    // Single byte then drain.
    do_reset();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1.valid", 32'(valid), 1);
    chk("t1.data", 32'(data), 32'h1C);
    chk("t1.level", 32'(level), 1);
    pop_n(1);
    chk("t1.valid_after_pop", 32'(valid), 0);

    // Overflow with FIFO full, then ordered drain.
    do_reset();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2.level", 32'(level), CAP);
    chk("t2.overflow", 32'(overflow), 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t2.pop%0d", i), 32'(data), 32'(i));
      pop_n(1);
    end
    chk("t2.empty", 32'(valid), 0);

    // Full FIFO with a pop on the push edge: no overflow, level holds.
    do_reset();
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("tfp.level", 32'(level), CAP);
    chk("tfp.overflow", 32'(overflow), 0);
    while (mq.size() != 0) begin
      check_model("tfp.drain");
      pop_n(1);
    end

    // Parity failure and clear.
    do_reset();
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3.parity_err", 32'(parity_err), 1);
    chk("t3.level", 32'(level), 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("t3.cleared", 32'(parity_err), 0);

    // Watchdog abort mid-frame, then a clean frame.
    do_reset();
    send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5, 1'b0);
    tick(TO + 2);
    chk("t4.frame_err", 32'(frame_err), 1);
    chk("t4.level", 32'(level), 0);
    m_frm = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4.data", 32'(data), 32'h5A);
    check_model("t4");

    // Glitches on the PS/2 clock are filtered out.
    do_reset();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5.data", 32'(data), 32'hF0);
    check_model("t5");

    // Reset mid-frame.
    do_reset();
    send_frame(8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bits({1'b1, 1'b1, 8'h99, 1'b0}, 4, 1'b0);
    clrn = 1'b0;
    tick(1);
    clrn = 1'b1;
    chk("t6.reset_outputs", 32'({level, valid, overflow, parity_err, frame_err}), 0);
    mq.delete();
    m_ovf = 1'b0; m_par = 1'b0; m_frm = 1'b0;
    tick(2);
    send_frame(8'h12, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6.data", 32'(data), 32'h12);
    chk("t6.valid", 32'(valid), 1);
    check_model("t6");

    // Random frames, errors, pops and clears against the model.
    do_reset();
    for (int it = 0; it < 60; it++) begin
      int kind;
      kind = $urandom_range(0, 7);
      send_frame(8'($urandom), kind == 0, kind != 1, kind == 2, 1'b0);
      pop_n($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) begin
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        m_ovf = 1'b0; m_par = 1'b0; m_frm = 1'b0;
      end
      check_model($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
